pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter LIVES, default 3, balls per game; legal range 1..3.
REQ-002 Parameter TIMER_FRAMES, default 120, pause length in frames (2 s at 60 Hz); legal range 1..127.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_tick  input  1  one-cycle pulse per frame, driven by the frame counter's frame_end.
REQ-006 btn  input  2  player buttons; "pressed" means btn != 2'b00.
REQ-007 hit  input  1  one-cycle pulse, ball struck a paddle.
REQ-008 miss  input  1  one-cycle pulse, ball passed a paddle.
REQ-009 state  output  2  game state: 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
REQ-010 graph_still  output  1  1 = freeze ball and paddle motion.
REQ-011 ball_reload  output  1  one-cycle pulse, recentre the ball.
REQ-012 timer_up  output  1  pause timer has expired.
REQ-013 lives  output  2  balls remaining.
REQ-014 score_tens, score_ones  output  4 each  BCD score, 00..99.

Function
REQ-015 The block SHALL hold all outputs in registers, with no combinational path from any input to any output.
REQ-016 The block SHALL contain a 7-bit pause timer:
- loads TIMER_FRAMES on every entry to NEWBALL or OVER;
- otherwise decrements by 1 on each frame_tick while nonzero;
- holds at 0.
REQ-017 timer_up SHALL equal (timer == 0), registered so it reflects the timer value currently held.
REQ-018 NEWGAME SHALL:
- hold graph_still=1;
- force lives=LIVES and score=00;
- move to PLAY on the first cycle btn is pressed.
REQ-019 PLAY SHALL hold graph_still=0.
REQ-020 In PLAY, hit with no miss SHALL increment the BCD score one cycle later:
- ones 9 -> 0 with tens +1;
- 99 -> 00 (wrap).
REQ-021 In PLAY, a miss with lives > 1 SHALL, on the next edge:
- decrement lives;
- move to NEWBALL;
- load the timer.
REQ-022 In PLAY, a miss with lives == 1 SHALL, on the next edge:
- set lives=0;
- move to OVER;
- load the timer.
REQ-023 When hit and miss coincide in PLAY, the miss SHALL take priority and the hit SHALL be discarded, with the score unchanged.
REQ-024 hit and miss SHALL be ignored in every state other than PLAY.
REQ-025 NEWBALL SHALL hold graph_still=1 and move to PLAY only when timer_up=1 and btn is pressed in the same cycle.
- A button held from before expiry qualifies.
REQ-026 OVER SHALL hold graph_still=1 and move to NEWGAME on the first cycle with timer_up=1.
- btn is ignored in OVER.
REQ-027 ball_reload SHALL pulse high for exactly one cycle, in the cycle after any transition into PLAY (from NEWGAME or NEWBALL).
- It SHALL be low at all other times.
REQ-028 frame_tick coinciding with a timer load SHALL be ignored: the load wins.
REQ-029 With TIMER_FRAMES=1, timer_up SHALL assert after exactly one frame_tick.
REQ-030 Behaviour with illegal parameter values is undefined.
- The bench SHALL not exercise it.

Reset
REQ-031 While reset=1 at a rising edge, the block SHALL set:
- state=NEWGAME, graph_still=1, ball_reload=0;
- timer=0 (so timer_up=1);
- lives=LIVES, score_tens=0, score_ones=0.
REQ-032 Reset asserted mid-game, in any state and at any timer value, SHALL take effect on the next edge and override every other input.
REQ-033 No ball_reload pulse SHALL be generated by reset.

Verification
REQ-034 Scenario "start game": reset, then btn=01 for 1 cycle.
- Next edge: state=PLAY, graph_still=0.
- Following cycle: ball_reload=1 for 1 cycle.
- lives=3, score=00.
REQ-035 Scenario "score carry and wrap": in PLAY, apply 10 hit pulses.
- Score reads 10.
- Continue to 100 total hits; score reads 00.
REQ-036 Scenario "lose a ball": in PLAY with lives=3, pulse miss.
- lives=2, state=NEWBALL, timer_up=0.
- Hold btn=10 throughout; after 120 frame_ticks: timer_up=1, then state=PLAY next edge, ball_reload pulses.
REQ-037 Scenario "game over": lives=1, pulse miss.
- state=OVER, lives=0.
- After 120 frame_ticks: state=NEWGAME, lives=3, score=00; btn stays ignored until NEWGAME.
REQ-038 Scenario "simultaneous hit+miss": score=07, lives=2, pulse hit and miss in the same cycle.
- score stays 07, lives=1, state=NEWBALL.
REQ-039 Scenario "reset mid-pause": in NEWBALL with timer=50, assert reset 1 cycle.
- All REQ-031 values next edge.
- No ball_reload pulse.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game controller: game-state FSM, pause timer, lives counter and BCD score.
// Every output is a flop; next values are computed in a single always_comb.
module pong_game_ctrl #(
   parameter int LIVES        = 3,
   parameter int TIMER_FRAMES = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic [1:0] btn,
   input  logic       hit,
   input  logic       miss,
   output logic [1:0] state,
   output logic       graph_still,
   output logic       ball_reload,
   output logic       timer_up,
   output logic [1:0] lives,
   output logic [3:0] score_tens,
   output logic [3:0] score_ones
);

   typedef enum logic [1:0] {
      ST_NEWGAME = 2'b00,
      ST_PLAY    = 2'b01,
      ST_NEWBALL = 2'b10,
      ST_OVER    = 2'b11
   } state_t;

   localparam logic [1:0] LIVES_INIT = 2'(LIVES);
   localparam logic [6:0] TIMER_INIT = 7'(TIMER_FRAMES);

   state_t     state_q, state_d;
   logic [6:0] timer_q, timer_d;
   logic       timer_up_q, timer_up_d;
   logic [1:0] lives_q, lives_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic       graph_still_q, graph_still_d;
   logic       reload_pend_q, reload_pend_d;
   logic       ball_reload_q, ball_reload_d;
   logic       timer_load;
   logic       pressed;

   assign pressed = (btn != 2'b00);

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      lives_d       = lives_q;
      tens_d        = tens_q;
      ones_d        = ones_q;
      reload_pend_d = 1'b0;
      ball_reload_d = reload_pend_q;
      timer_load    = 1'b0;

      if (frame_tick && (timer_q != '0)) begin
         timer_d = timer_q - 7'd1;
      end

      unique case (state_q)
         ST_NEWGAME: begin
            lives_d = LIVES_INIT;
            tens_d  = '0;
            ones_d  = '0;
            if (pressed) begin
               state_d       = ST_PLAY;
               reload_pend_d = 1'b1;
            end
         end
         ST_PLAY: begin
            // A miss outranks a coincident hit; the hit is simply dropped.
            if (miss) begin
               timer_load = 1'b1;
               if (lives_q > 2'd1) begin
                  lives_d = lives_q - 2'd1;
                  state_d = ST_NEWBALL;
               end else begin
                  lives_d = '0;
                  state_d = ST_OVER;
               end
            end else if (hit) begin
               if (ones_q == 4'd9) begin
                  ones_d = '0;
                  tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
               end else begin
                  ones_d = ones_q + 4'd1;
               end
            end
         end
         ST_NEWBALL: begin
            if (timer_up_q && pressed) begin
               state_d       = ST_PLAY;
               reload_pend_d = 1'b1;
            end
         end
         ST_OVER: begin
            if (timer_up_q) begin
               state_d = ST_NEWGAME;
               lives_d = LIVES_INIT;
               tens_d  = '0;
               ones_d  = '0;
            end
         end
      endcase

      // Loading wins over a frame_tick arriving in the same cycle.
      if (timer_load) begin
         timer_d = TIMER_INIT;
      end

      timer_up_d    = (timer_d == '0);
      graph_still_d = (state_d != ST_PLAY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_NEWGAME;
         timer_q       <= '0;
         timer_up_q    <= 1'b1;
         lives_q       <= LIVES_INIT;
         tens_q        <= '0;
         ones_q        <= '0;
         graph_still_q <= 1'b1;
         reload_pend_q <= 1'b0;
         ball_reload_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         timer_up_q    <= timer_up_d;
         lives_q       <= lives_d;
         tens_q        <= tens_d;
         ones_q        <= ones_d;
         graph_still_q <= graph_still_d;
         reload_pend_q <= reload_pend_d;
         ball_reload_q <= ball_reload_d;
      end
   end

   assign state       = state_q;
   assign graph_still = graph_still_q;
   assign ball_reload = ball_reload_q;
   assign timer_up    = timer_up_q;
   assign lives       = lives_q;
   assign score_tens  = tens_q;
   assign score_ones  = ones_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: default instance plus a LIVES=1, TIMER_FRAMES=1 instance.
module tb_pong_game_ctrl;

   localparam logic [1:0] S_NEWGAME = 2'b00;
   localparam logic [1:0] S_PLAY    = 2'b01;
   localparam logic [1:0] S_NEWBALL = 2'b10;
   localparam logic [1:0] S_OVER    = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick, hit, miss;
   logic [1:0] btn;
   logic [1:0] state;
   logic       graph_still, ball_reload, timer_up;
   logic [1:0] lives;
   logic [3:0] score_tens, score_ones;

   logic       frame_tick1, hit1, miss1;
   logic [1:0] btn1;
   logic [1:0] state1;
   logic       graph_still1, ball_reload1, timer_up1;
   logic [1:0] lives1;
   logic [3:0] score_tens1, score_ones1;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   pong_game_ctrl #(.LIVES(3), .TIMER_FRAMES(120)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn),
      .hit(hit), .miss(miss), .state(state), .graph_still(graph_still),
      .ball_reload(ball_reload), .timer_up(timer_up), .lives(lives),
      .score_tens(score_tens), .score_ones(score_ones)
   );

   pong_game_ctrl #(.LIVES(1), .TIMER_FRAMES(1)) dut1 (
      .clk(clk), .reset(reset), .frame_tick(frame_tick1), .btn(btn1),
      .hit(hit1), .miss(miss1), .state(state1), .graph_still(graph_still1),
      .ball_reload(ball_reload1), .timer_up(timer_up1), .lives(lives1),
      .score_tens(score_tens1), .score_ones(score_ones1)
   );

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic frames(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
         tick();
      end
   endtask

   task automatic hits(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         hit = 1'b1;
         tick();
         hit = 1'b0;
         tick();
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 32'(state), 32'(S_NEWGAME));
      check({tag, "_still"}, 32'(graph_still), 32'd1);
      check({tag, "_reload"}, 32'(ball_reload), 32'd0);
      check({tag, "_timer_up"}, 32'(timer_up), 32'd1);
      check({tag, "_lives"}, 32'(lives), 32'd3);
      check({tag, "_score"}, 32'({score_tens, score_ones}), 32'h00);
   endtask

   initial begin
      reset = 1'b1;
      frame_tick = 1'b0; hit = 1'b0; miss = 1'b0; btn = 2'b00;
      frame_tick1 = 1'b0; hit1 = 1'b0; miss1 = 1'b0; btn1 = 2'b00;
      @(negedge clk);
      tick();
      check_reset_values("rst");
      reset = 1'b0;

      miss = 1'b1; hit = 1'b1;
      tick();
      miss = 1'b0; hit = 1'b0;
      check("newgame_ignore_miss_lives", 32'(lives), 32'd3);
      check("newgame_ignore_miss_state", 32'(state), 32'(S_NEWGAME));
      check("newgame_ignore_hit_score", 32'({score_tens, score_ones}), 32'h00);

      // Single-frame timer, single life
      btn1 = 2'b01;
      tick();
      btn1 = 2'b00;
      check("t1_play", 32'(state1), 32'(S_PLAY));
      miss1 = 1'b1;
      tick();
      miss1 = 1'b0;
      check("t1_over", 32'(state1), 32'(S_OVER));
      check("t1_lives0", 32'(lives1), 32'd0);
      check("t1_timer_up_low", 32'(timer_up1), 32'd0);
      tick();
      check("t1_no_tick_hold", 32'(timer_up1), 32'd0);
      frame_tick1 = 1'b1;
      tick();
      frame_tick1 = 1'b0;
      check("t1_timer_up_after_one", 32'(timer_up1), 32'd1);
      check("t1_still_over", 32'(state1), 32'(S_OVER));
      tick();
      check("t1_newgame", 32'(state1), 32'(S_NEWGAME));
      check("t1_lives_restored", 32'(lives1), 32'd1);

      // Start game
      btn = 2'b01;
      tick();
      btn = 2'b00;
      check("start_state", 32'(state), 32'(S_PLAY));
      check("start_still", 32'(graph_still), 32'd0);
      check("start_reload_not_yet", 32'(ball_reload), 32'd0);
      tick();
      check("start_reload_pulse", 32'(ball_reload), 32'd1);
      tick();
      check("start_reload_end", 32'(ball_reload), 32'd0);
      check("start_lives", 32'(lives), 32'd3);
      check("start_score", 32'({score_tens, score_ones}), 32'h00);

      // Score carry and wrap
      hits(9);
      check("score_09", 32'({score_tens, score_ones}), 32'h09);
      hits(1);
      check("score_10", 32'({score_tens, score_ones}), 32'h10);
      hits(89);
      check("score_99", 32'({score_tens, score_ones}), 32'h99);
      hits(1);
      check("score_wrap_00", 32'({score_tens, score_ones}), 32'h00);
      hits(7);
      check("score_07", 32'({score_tens, score_ones}), 32'h07);

      // Lose a ball with btn held throughout the pause
      btn = 2'b10;
      miss = 1'b1;
      tick();
      miss = 1'b0;
      check("lose_lives", 32'(lives), 32'd2);
      check("lose_state", 32'(state), 32'(S_NEWBALL));
      check("lose_timer_up", 32'(timer_up), 32'd0);
      check("lose_still", 32'(graph_still), 32'd1);
      hits(1);
      check("newball_ignore_hit", 32'({score_tens, score_ones}), 32'h07);
      frames(119);
      check("lose_119_timer_up", 32'(timer_up), 32'd0);
      check("lose_119_state", 32'(state), 32'(S_NEWBALL));
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      check("lose_120_timer_up", 32'(timer_up), 32'd1);
      check("lose_120_state", 32'(state), 32'(S_NEWBALL));
      tick();
      check("resume_state", 32'(state), 32'(S_PLAY));
      check("resume_reload_not_yet", 32'(ball_reload), 32'd0);
      tick();
      check("resume_reload_pulse", 32'(ball_reload), 32'd1);
      btn = 2'b00;
      tick();
      check("resume_reload_end", 32'(ball_reload), 32'd0);

      // Simultaneous hit+miss, frame_tick on the load cycle
      hit = 1'b1; miss = 1'b1; frame_tick = 1'b1;
      tick();
      hit = 1'b0; miss = 1'b0; frame_tick = 1'b0;
      check("hm_score", 32'({score_tens, score_ones}), 32'h07);
      check("hm_lives", 32'(lives), 32'd1);
      check("hm_state", 32'(state), 32'(S_NEWBALL));
      frames(119);
      check("hm_load_wins_timer_up", 32'(timer_up), 32'd0);
      frames(1);
      check("hm_120_timer_up", 32'(timer_up), 32'd1);
      tick();
      check("newball_waits_btn", 32'(state), 32'(S_NEWBALL));
      btn = 2'b01;
      tick();
      btn = 2'b00;
      check("hm_resume_state", 32'(state), 32'(S_PLAY));
      tick();
      check("hm_resume_reload", 32'(ball_reload), 32'd1);

      // Game over with btn held (ignored in OVER)
      btn = 2'b11;
      miss = 1'b1;
      tick();
      miss = 1'b0;
      check("over_state", 32'(state), 32'(S_OVER));
      check("over_lives", 32'(lives), 32'd0);
      check("over_timer_up", 32'(timer_up), 32'd0);
      frames(119);
      check("over_119_state", 32'(state), 32'(S_OVER));
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      check("over_120_timer_up", 32'(timer_up), 32'd1);
      check("over_120_state", 32'(state), 32'(S_OVER));
      tick();
      check("over_newgame_state", 32'(state), 32'(S_NEWGAME));
      check("over_newgame_lives", 32'(lives), 32'd3);
      check("over_newgame_score", 32'({score_tens, score_ones}), 32'h00);
      check("over_newgame_reload", 32'(ball_reload), 32'd0);
      tick();
      check("restart_state", 32'(state), 32'(S_PLAY));
      tick();
      check("restart_reload", 32'(ball_reload), 32'd1);
      btn = 2'b00;

      // Reset mid-pause at timer=50
      hits(3);
      miss = 1'b1;
      tick();
      miss = 1'b0;
      check("rmp_state", 32'(state), 32'(S_NEWBALL));
      frames(70);
      check("rmp_timer_up", 32'(timer_up), 32'd0);
      reset = 1'b1;
      btn = 2'b01;
      tick();
      reset = 1'b0;
      btn = 2'b00;
      check_reset_values("rmp");
      tick();
      check("rmp_no_reload1", 32'(ball_reload), 32'd0);
      tick();
      check("rmp_no_reload2", 32'(ball_reload), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
